// File: rtl/microtest_monitor.sv
// microtest_monitor: scores microcode self-test runs against a runtime-loaded label table.
// Define TESTMON_SKIP_EN to enable skip entries that redirect the uPC.
module microtest_monitor #(
  parameter int AW      = 12,
  parameter int NLABELS = 16,
  parameter int LIMIT   = 100000,
  parameter int CW      = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         x_valid,
  input  logic [AW-1:0]                x_pc,
  input  logic [3:0]                   x_sqi,
  input  logic [AW-1:0]                x_a,
  input  logic [AW-1:0]                f_pc,
  input  logic                         cfg_we,
  input  logic [$clog2(NLABELS)-1:0]   cfg_idx,
  input  logic [1:0]                   cfg_kind,
  input  logic [AW-1:0]                cfg_addr,
  input  logic                         cfg_valid,
  input  logic [AW-1:0]                cfg_target,
  output logic [2:0]                   state,
  output logic [1:0]                   fail_code,
  output logic [AW-1:0]                fail_pc,
  output logic                         pass_stb,
  output logic [$clog2(NLABELS)-1:0]   pass_idx,
  output logic [NLABELS-1:0]           pass_mask,
  output logic [$clog2(NLABELS+1)-1:0] pass_count,
  output logic                         redirect_stb,
  output logic [AW-1:0]                redirect_pc
);

  localparam int IW = $clog2(NLABELS);
  localparam int NW = $clog2(NLABELS + 1);
  localparam logic [CW-1:0] LIM_M1 = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);
  localparam logic [3:0] SQI_CONT = 4'd14;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    K_PASS = 2'd0,
    K_FAIL = 2'd1,
    K_DONE = 2'd2,
    K_SKIP = 2'd3
  } kind_t;

  state_t             st;
  logic [NLABELS-1:0] lbl_valid;
  kind_t              lbl_kind [NLABELS];
  logic [AW-1:0]      lbl_addr [NLABELS];
  logic [CW-1:0]      wd_cnt;

  logic               fail_hit, done_hit, pass_hit, all_pass, wd_expire;
  logic [IW-1:0]      pass_sel;
  logic [NLABELS-1:0] pass_need, pass_got;
  logic               skip_hit;
  logic [AW-1:0]      skip_pc;

  always_comb begin
    fail_hit  = 1'b0;
    done_hit  = 1'b0;
    pass_hit  = 1'b0;
    pass_sel  = '0;
    pass_need = '0;
    for (int unsigned i = 0; i < NLABELS; i++) begin
      if (lbl_valid[i] && lbl_kind[i] == K_PASS) pass_need[i] = 1'b1;
      if (st == S_RUN && x_valid && lbl_valid[i]) begin
        if (lbl_kind[i] == K_FAIL && x_pc == lbl_addr[i]) fail_hit = 1'b1;
        if (lbl_kind[i] == K_DONE && x_pc == lbl_addr[i]) done_hit = 1'b1;
        if (lbl_kind[i] == K_PASS && x_sqi == SQI_CONT && x_a == lbl_addr[i] && !pass_hit) begin
          pass_hit = 1'b1;
          pass_sel = IW'(i);
        end
      end
    end
  end

  // A pass hit coinciding with done still counts toward completeness.
  assign pass_got  = pass_mask | (pass_hit ? (NLABELS'(1) << pass_sel) : '0);
  assign all_pass  = (pass_need & ~pass_got) == '0;
  assign wd_expire = (LIMIT != 0) && (wd_cnt == LIM_M1);

`ifdef TESTMON_SKIP_EN
  logic [AW-1:0] lbl_target [NLABELS];

  always_comb begin
    skip_hit = 1'b0;
    skip_pc  = '0;
    for (int unsigned i = 0; i < NLABELS; i++) begin
      if (st == S_RUN && x_valid && lbl_valid[i] && lbl_kind[i] == K_SKIP &&
          x_pc == lbl_addr[i] && f_pc == lbl_addr[i] + AW'(1) && !skip_hit) begin
        skip_hit = 1'b1;
        skip_pc  = lbl_target[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lbl_target <= '{default: '0};
    end else if (cfg_we && st != S_RUN) begin
      lbl_target[cfg_idx] <= cfg_target;
    end
  end
`else
  logic unused_skip;
  assign skip_hit    = 1'b0;
  assign skip_pc     = '0;
  assign unused_skip = ^{f_pc, cfg_target};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st           <= S_IDLE;
      lbl_valid    <= '0;
      lbl_kind     <= '{default: K_PASS};
      lbl_addr     <= '{default: '0};
      wd_cnt       <= '0;
      fail_code    <= '0;
      fail_pc      <= '0;
      pass_stb     <= 1'b0;
      pass_idx     <= '0;
      pass_mask    <= '0;
      pass_count   <= '0;
      redirect_stb <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      pass_stb     <= 1'b0;
      redirect_stb <= 1'b0;
      if (st != S_RUN) begin
        if (cfg_we) begin
          lbl_valid[cfg_idx] <= cfg_valid;
          lbl_kind[cfg_idx]  <= kind_t'(cfg_kind);
          lbl_addr[cfg_idx]  <= cfg_addr;
        end
        if (start) begin
          st         <= S_RUN;
          pass_mask  <= '0;
          pass_count <= '0;
          fail_code  <= '0;
          fail_pc    <= '0;
          wd_cnt     <= '0;
        end
      end else begin
        if (wd_cnt != '1) wd_cnt <= wd_cnt + CW'(1);
        if (fail_hit) begin
          st        <= S_FAIL;
          fail_code <= 2'd1;
          fail_pc   <= x_pc;
        end else if (done_hit) begin
          if (all_pass) begin
            st <= S_PASS;
          end else begin
            st        <= S_FAIL;
            fail_code <= 2'd2;
            fail_pc   <= x_pc;
          end
        end else if (wd_expire) begin
          st        <= S_TIMEOUT;
          fail_code <= 2'd3;
          fail_pc   <= x_pc;
        end else begin
          if (pass_hit) begin
            pass_stb <= 1'b1;
            pass_idx <= pass_sel;
            if (!pass_mask[pass_sel]) begin
              pass_mask[pass_sel] <= 1'b1;
              pass_count          <= pass_count + NW'(1);
            end
          end
          if (skip_hit) begin
            redirect_stb <= 1'b1;
            redirect_pc  <= skip_pc;
          end
        end
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_microtest_monitor.sv
// Testbench for microtest_monitor: directed scenarios plus randomized traffic against a behavioural model.
module tb_microtest_monitor;

  localparam int AW  = 12;
  localparam int NL  = 16;
  localparam int LIM = 20;
  localparam int CW  = 32;
  localparam int IW  = $clog2(NL);
  localparam int NCW = $clog2(NL + 1);

  logic            clk = 1'b0;
  logic            reset_n, start, x_valid, cfg_we, cfg_valid;
  logic [AW-1:0]   x_pc, x_a, f_pc, cfg_addr, cfg_target;
  logic [3:0]      x_sqi;
  logic [IW-1:0]   cfg_idx;
  logic [1:0]      cfg_kind;
  logic [2:0]      state;
  logic [1:0]      fail_code;
  logic [AW-1:0]   fail_pc, redirect_pc;
  logic            pass_stb, redirect_stb;
  logic [IW-1:0]   pass_idx;
  logic [NL-1:0]   pass_mask;
  logic [NCW-1:0]  pass_count;

  microtest_monitor #(.AW(AW), .NLABELS(NL), .LIMIT(LIM), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .x_valid(x_valid), .x_pc(x_pc),
    .x_sqi(x_sqi), .x_a(x_a), .f_pc(f_pc), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_kind(cfg_kind), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid), .cfg_target(cfg_target),
    .state(state), .fail_code(fail_code), .fail_pc(fail_pc), .pass_stb(pass_stb),
    .pass_idx(pass_idx), .pass_mask(pass_mask), .pass_count(pass_count),
    .redirect_stb(redirect_stb), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: state 0 idle, 1 run, 2 pass, 3 fail, 4 timeout.
  int          m_st, m_idx, m_fcode, m_fpc, m_rpc;
  longint      m_cnt;
  bit [NL-1:0] m_mask;
  bit          m_stb, m_rstb;
  bit          t_v [NL];
  int          t_k [NL];
  int          t_a [NL];
  int          t_t [NL];

  function automatic void model_reset();
    m_st = 0; m_idx = 0; m_fcode = 0; m_fpc = 0; m_rpc = 0; m_cnt = 0;
    m_mask = '0; m_stb = 0; m_rstb = 0;
    for (int i = 0; i < NL; i++) begin
      t_v[i] = 0; t_k[i] = 0; t_a[i] = 0; t_t[i] = 0;
    end
  endfunction

  function automatic void model_step();
    int          pmin;
    bit          fl, dn, expire;
    bit [NL-1:0] need, have;
`ifdef TESTMON_SKIP_EN
    bit          sk;
    int          sk_t;
    sk = 0; sk_t = 0;
`endif
    m_stb = 0; m_rstb = 0;
    if (m_st != 1) begin
      if (cfg_we) begin
        t_v[cfg_idx] = cfg_valid; t_k[cfg_idx] = cfg_kind;
        t_a[cfg_idx] = cfg_addr;  t_t[cfg_idx] = cfg_target;
      end
      if (start) begin
        m_st = 1; m_mask = '0; m_fcode = 0; m_fpc = 0; m_cnt = 0;
      end
      return;
    end
    pmin = -1; fl = 0; dn = 0; need = '0;
    for (int i = NL - 1; i >= 0; i--) begin
      if (t_v[i] && t_k[i] == 0) need[i] = 1;
      if (x_valid && t_v[i]) begin
        case (t_k[i])
          0: if (x_sqi == 14 && x_a == t_a[i]) pmin = i;
          1: if (x_pc == t_a[i]) fl = 1;
          2: if (x_pc == t_a[i]) dn = 1;
`ifdef TESTMON_SKIP_EN
          3: if (x_pc == t_a[i] && f_pc == (t_a[i] + 1) % (1 << AW)) begin sk = 1; sk_t = t_t[i]; end
`endif
          default: ;
        endcase
      end
    end
    expire = (LIM != 0) && (m_cnt == LIM - 1);
    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    have = m_mask;
    if (pmin >= 0) have[pmin] = 1;
    if (fl) begin
      m_st = 3; m_fcode = 1; m_fpc = x_pc;
    end else if (dn) begin
      if ((need & ~have) == '0) m_st = 2;
      else begin m_st = 3; m_fcode = 2; m_fpc = x_pc; end
    end else if (expire) begin
      m_st = 4; m_fcode = 3; m_fpc = x_pc;
    end else begin
      if (pmin >= 0) begin m_stb = 1; m_idx = pmin; m_mask[pmin] = 1; end
`ifdef TESTMON_SKIP_EN
      if (sk) begin m_rstb = 1; m_rpc = sk_t; end
`endif
    end
  endfunction

  task automatic check_all();
    check("state", 32'(state), 32'(m_st));
    check("fail_code", 32'(fail_code), 32'(m_fcode));
    check("fail_pc", 32'(fail_pc), 32'(m_fpc));
    check("pass_stb", 32'(pass_stb), 32'(m_stb));
    check("pass_idx", 32'(pass_idx), 32'(m_idx));
    check("pass_mask", 32'(pass_mask), 32'(m_mask));
    check("pass_count", 32'(pass_count), 32'($countones(m_mask)));
    check("redirect_stb", 32'(redirect_stb), 32'(m_rstb));
    check("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
  endtask

  task automatic idle_in();
    start = 0; x_valid = 0; x_pc = '0; x_sqi = '0; x_a = '0; f_pc = '0;
    cfg_we = 0; cfg_idx = '0; cfg_kind = '0; cfg_addr = '0; cfg_valid = 0; cfg_target = '0;
  endtask

  // Inputs are driven at negedge; outputs sampled 1 time unit after posedge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic cfg(input int idx, input int kind, input int addr, input bit valid, input int tgt);
    cfg_we = 1; cfg_idx = IW'(idx); cfg_kind = 2'(kind); cfg_addr = AW'(addr);
    cfg_valid = valid; cfg_target = AW'(tgt);
    cycle();
    cfg_we = 0;
  endtask

  task automatic do_start();
    start = 1;
    cycle();
    start = 0;
  endtask

  task automatic exec(input int pc, input int sqi, input int a, input int fpc);
    x_valid = 1; x_pc = AW'(pc); x_sqi = 4'(sqi); x_a = AW'(a); f_pc = AW'(fpc);
    cycle();
    x_valid = 0;
  endtask

  int pool [8] = '{0, 1, 2, 3, 4, 5, 4094, 4095};

  initial begin
    idle_in();
    reset_n = 1;
    model_reset();
    @(negedge clk);
    do_reset();
    check("reset_state", 32'(state), 32'd0);

    // Complete run: two checkpoints then done.
    cfg(0, 0, 12, 1, 0);
    cfg(1, 0, 28, 1, 0);
    cfg(2, 2, 1563, 1, 0);
    do_start();
    check("start_run", 32'(state), 32'd1);
    exec(100, 14, 12, 101);
    check("hit0_stb", 32'(pass_stb), 32'd1);
    check("hit0_idx", 32'(pass_idx), 32'd0);
    exec(101, 14, 28, 102);
    check("hit1_idx", 32'(pass_idx), 32'd1);
    exec(1563, 0, 0, 1564);
    check("done_pass", 32'(state), 32'd2);
    check("done_count", 32'(pass_count), 32'd2);

    // Missing checkpoint.
    do_start();
    exec(100, 14, 12, 101);
    exec(1563, 0, 0, 1564);
    check("miss_state", 32'(state), 32'd3);
    check("miss_code", 32'(fail_code), 32'd2);
    check("miss_pc", 32'(fail_pc), 32'd1563);
    check("miss_mask", 32'(pass_mask), 32'h1);

    // Fail beats pass at the same address.
    cfg(3, 1, 1665, 1, 0);
    cfg(4, 0, 1665, 1, 0);
    do_start();
    exec(1665, 14, 1665, 1666);
    check("trap_state", 32'(state), 32'd3);
    check("trap_code", 32'(fail_code), 32'd1);
    check("trap_stb", 32'(pass_stb), 32'd0);
    cfg(3, 1, 1665, 0, 0);
    cfg(4, 0, 1665, 0, 0);

    // Watchdog expiry on the LIM-th RUN clock, then restart keeps the table.
    do_start();
    for (int i = 0; i < LIM - 1; i++) cycle();
    check("wd_pre", 32'(state), 32'd1);
    cycle();
    check("wd_state", 32'(state), 32'd4);
    check("wd_code", 32'(fail_code), 32'd3);
    do_start();
    check("restart_state", 32'(state), 32'd1);
    check("restart_code", 32'(fail_code), 32'd0);
    exec(7, 14, 12, 8);
    check("kept_table", 32'(pass_stb), 32'd1);

    // Asynchronous reset mid-run, then cfg writes during RUN are ignored.
    #3;
    do_reset();
    check("mid_reset_state", 32'(state), 32'd0);
    check("mid_reset_count", 32'(pass_count), 32'd0);
    do_start();
    cfg(5, 2, 200, 1, 0);
    exec(200, 0, 0, 201);
    check("cfg_in_run", 32'(state), 32'd1);
    exec(1563, 14, 12, 1564);
    check("table_cleared", 32'(state), 32'd1);

    // Skip redirect.
    do_reset();
    cfg(6, 3, 43, 1, 53);
    do_start();
    exec(43, 0, 0, 44);
`ifdef TESTMON_SKIP_EN
    check("skip_stb", 32'(redirect_stb), 32'd1);
    check("skip_pc", 32'(redirect_pc), 32'd53);
`else
    check("skip_stb_off", 32'(redirect_stb), 32'd0);
`endif
    cycle();
    check("skip_stb_drop", 32'(redirect_stb), 32'd0);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle_in();
      start   = ($urandom_range(9) == 0);
      x_valid = ($urandom_range(4) != 0);
      x_pc    = AW'(pool[$urandom_range(7)]);
      x_a     = AW'(pool[$urandom_range(7)]);
      x_sqi   = ($urandom_range(1) == 0) ? 4'd14 : 4'($urandom_range(15));
      f_pc    = ($urandom_range(1) == 0) ? x_pc + AW'(1) : AW'(pool[$urandom_range(7)]);
      if ($urandom_range(4) == 0) begin
        cfg_we     = 1;
        cfg_idx    = IW'($urandom_range(NL - 1));
        cfg_kind   = 2'($urandom_range(3));
        cfg_addr   = AW'(pool[$urandom_range(7)]);
        cfg_valid  = ($urandom_range(3) != 0);
        cfg_target = AW'($urandom);
      end
      if ($urandom_range(499) == 0) begin
        #2;
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/microtest_monitor.md
Name: microtest_monitor

Overview:
- Synthesizable monitor for the microsequencer execution stage. It scores microcode self-test runs in hardware, so long test ROMs can run on FPGA without a simulator.
- A runtime-loaded label table classifies executed microinstructions as pass checkpoints, fail traps or the completion point.
- Tracks which checkpoints were hit, runs a cycle watchdog, and reports a final verdict to the debug/status block.

Parameters:
- AW, 12, microinstruction address width (uPC).
- NLABELS, 16, label table entries.
- LIMIT, 100000, watchdog limit in RUN cycles; 0 disables the watchdog.
- CW, 32, watchdog counter width; must satisfy LIMIT < 2**CW.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin/restart a scoring run.
- x_valid  in  1  execution stage holds a valid microinstruction this cycle.
- x_pc  in  AW  uPC of the executing microinstruction.
- x_sqi  in  4  sequencer opcode field (opcode bits 112:109).
- x_a  in  AW  sequencer address field (opcode bits 108:97).
- f_pc  in  AW  uPC at fetch stage (next address).
- cfg_we  in  1  label table write strobe.
- cfg_idx  in  $clog2(NLABELS)  entry index.
- cfg_kind  in  2  entry kind: 0 pass, 1 fail, 2 done, 3 skip.
- cfg_addr  in  AW  label address; cfg_valid=0 invalidates the entry.
- cfg_valid  in  1  entry valid.
- cfg_target  in  AW  redirect target (skip entries only).
- state  out  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT.
- fail_code  out  2  0 none, 1 fail label, 2 missing checkpoint, 3 timeout.
- fail_pc  out  AW  x_pc at the fail event.
- pass_stb  out  1  one-cycle pulse per checkpoint hit.
- pass_idx  out  $clog2(NLABELS)  entry index of the latest hit.
- pass_mask  out  NLABELS  checkpoints hit this run.
- pass_count  out  $clog2(NLABELS+1)  distinct checkpoints hit.
- redirect_stb  out  1  one-cycle pulse: force uPC.
- redirect_pc  out  AW  forced uPC value.

Behaviour:
- Async reset (reset_n=0), asserted at any time including mid-run: state=IDLE; table entries invalid; watchdog counter 0; all outputs 0.
- cfg_we is honoured only in IDLE, PASS, FAIL and TIMEOUT; it is ignored in RUN. The entry is written at the clock edge.
- start in IDLE, PASS, FAIL or TIMEOUT: go to RUN. Clear pass_mask, pass_count, fail_code, fail_pc and the watchdog counter. The table is kept. start in RUN is ignored.
- Matching is evaluated only in RUN with x_valid=1. All results are registered: outputs update 1 clk after the sampled cycle.
  - Pass entry i matches on x_sqi==14 (CONT) && x_a==addr_i.
  - Fail and done entries match on x_pc==addr.
- Priority in one cycle: fail > done > pass. Among multiple pass matches, the lowest index wins.
- Pass hit: pass_stb=1 and pass_idx=i. If mask bit i was clear, set it and increment pass_count. A repeat hit pulses pass_stb without incrementing.
- Fail hit: state goes to FAIL, fail_code=1, fail_pc=x_pc.
- Done hit:
  - If every valid pass entry's mask bit is set (including a pass hit in the same cycle): state goes to PASS.
  - Otherwise: state goes to FAIL, fail_code=2, fail_pc=x_pc.
- Watchdog: the counter increments on every RUN clock. When counter==LIMIT-1 and no fail/done event occurs that cycle: state goes to TIMEOUT, fail_code=3, fail_pc=x_pc. A fail/done event on the same cycle as expiry wins. The counter saturates.
- PASS, FAIL and TIMEOUT are sticky until start or reset. No matching is done in those states.
- Pulses (pass_stb, redirect_stb) are 0 in every state except RUN.
- Duplicate addresses across kinds are legal; the priority rules above resolve them.

Optional Feature:
- Macro: TESTMON_SKIP_EN.
- Defined:
  - A skip entry matches in RUN with x_valid when x_pc==addr && f_pc==addr+1 (modulo 2**AW).
  - On a match: redirect_stb pulses 1 clk later with redirect_pc=cfg_target as stored. The watchdog keeps counting.
  - Skip has the lowest priority: it is suppressed when a fail or done event occurs that cycle.
- Not defined: kind 3 entries never match; redirect_stb and redirect_pc are tied to 0; cfg_target is unused.

Test Plan:
- Load pass@12, pass@28, done@1563. Start, then drive CONT a=12, CONT a=28, x_pc=1563 -> two pass_stb with idx 0 then 1; pass_count=2; state=PASS.
- Same table; skip CONT a=28 -> at x_pc=1563: state=FAIL, fail_code=2, fail_pc=1563, pass_mask=...01.
- Load fail@1665 and pass@1665. Drive x_pc=1665 with CONT a=1665 -> state=FAIL, fail_code=1, no pass_stb.
- LIMIT=20, never hit done -> state=TIMEOUT on the 20th RUN clock, fail_code=3. Then start -> state=RUN, counters cleared, table kept.
- Drop reset_n mid-run after 1 pass hit -> immediate IDLE, pass_count=0, table invalid. A cfg_we during RUN leaves the entry unchanged.
- TESTMON_SKIP_EN: load skip addr=43 target=53. Drive x_pc=43, f_pc=44 -> redirect_stb one cycle later with redirect_pc=53. Without the macro -> redirect_stb stays 0.
